// File: rtl/fp_add_scheduler.sv
// rtl/fp_add_scheduler.sv - round-robin scheduler sharing one pipelined FP adder among NREQ requesters
// Optional statistics counters are enabled by defining FP_ADD_SCHED_STATS_EN.

`ifndef FP16
`define FP16 0
`endif
`ifndef FP32
`define FP32 1
`endif
`ifndef FP64
`define FP64 2
`endif
`ifndef GET_FP_LEN
`define GET_FP_LEN(f) (((f) == `FP16) ? 16 : (((f) == `FP64) ? 64 : 32))
`endif

module fp_add_scheduler #(
    parameter int DATA_FORMAT = `FP32,
    parameter int NREQ        = 4,
    parameter int LAT         = 3,
    parameter int FIFO_DEPTH  = 4,
    localparam int W          = `GET_FP_LEN(DATA_FORMAT),
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                add_valid,
    output logic [W-1:0]        add_a,
    output logic [W-1:0]        add_b,
    input  logic [W-1:0]        add_sum,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [W-1:0]        res_sum,
`ifdef FP_ADD_SCHED_STATS_EN
    output logic [IDW-1:0]      res_id,
    output logic [31:0]         stat_issued,
    output logic [31:0]         stat_stall
`else
    output logic [IDW-1:0]      res_id
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + LAT + 1);

    logic [IDW-1:0] last_q, last_d;
    logic [LAT-1:0] tag_v_q;
    logic [IDW-1:0] tag_id_q [LAT];
    logic [W-1:0]   mem_q    [FIFO_DEPTH];
    logic [IDW-1:0] mem_id_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           blank_q;

    logic [CW-1:0]  inflight;
    logic           open;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand;
    logic           issue;
    logic           push;
    logic           pop;

    // Credit covers both queued results and those still inside the adder.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(tag_v_q[i]);
        end
        open    = ((cnt_q + inflight) < CW'(FIFO_DEPTH)) && !rst && !blank_q;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_q) + k) % NREQ);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        issue     = open && gnt_vld;
        req_ready = issue ? (NREQ'(1) << gnt_idx) : '0;
        add_valid = issue;
        add_a     = issue ? req_a[int'(gnt_idx)*W +: W] : '0;
        add_b     = issue ? req_b[int'(gnt_idx)*W +: W] : '0;
        last_d    = issue ? gnt_idx : last_q;
    end

    always_comb begin
        push      = tag_v_q[LAT-1];
        res_valid = (cnt_q != '0) && !rst && !blank_q;
        pop       = res_valid && res_ready;
        res_sum   = res_valid ? mem_q[rd_q] : '0;
        res_id    = res_valid ? mem_id_q[rd_q] : '0;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        wr_d      = wr_q + AW'(push);
        rd_d      = rd_q + AW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= IDW'(NREQ - 1);
            tag_v_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            blank_q <= 1'b1;
        end else begin
            last_q  <= last_d;
            for (int i = LAT - 1; i > 0; i--) begin
                tag_v_q[i] <= tag_v_q[i-1];
            end
            tag_v_q[0] <= issue;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            blank_q <= 1'b0;
        end
    end

    // Payload storage carries no reset; validity lives in tag_v_q and cnt_q.
    always_ff @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            tag_id_q[i] <= tag_id_q[i-1];
        end
        tag_id_q[0] <= gnt_idx;
        if (push) begin
            mem_q[wr_q]    <= add_sum;
            mem_id_q[wr_q] <= tag_id_q[LAT-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (cnt_q == CW'(FIFO_DEPTH))));

`ifdef FP_ADD_SCHED_STATS_EN
    logic [31:0] issued_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (issue && (issued_q != '1)) issued_q <= issued_q + 32'd1;
            if ((|req_valid) && !issue && (stall_q != '1)) stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_issued = issued_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb/tb_fp_add_scheduler.sv - randomized scoreboard bench for fp_add_scheduler

module tb_fp_add_scheduler;

    localparam int NREQ  = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic              add_valid;
    logic [W-1:0]      add_a, add_b;
    logic [W-1:0]      add_sum = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [W-1:0]      res_sum;
    logic [1:0]        res_id;

    fp_add_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_id(res_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        int          id;
        int          rdy;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] sched[int];
    int          glog[$];
    int          mcyc = 0, m_last = NREQ - 1, m_out = 0;
    bit          m_blank = 1'b1;
    int          n_cmp = 0, n_fail = 0;
    int          n_iss = 0, n_pop = 0, n_rv = 0;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a + b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, mcyc);
        end
    endtask

    // Adder stand-in: answers exactly LAT cycles after each issue, junk otherwise.
    always @(posedge clk) begin
        #1;
        add_sum = sched.exists(mcyc) ? sched[mcyc] : $urandom();
    end

    logic [NREQ-1:0] e_rdy;
    logic [31:0]     e_a, e_b;
    bit              e_iss, e_rv, blocked, found, popped;
    int              g, c;

    always @(negedge clk) begin
        blocked = rst || m_blank;
        e_rdy = '0; e_iss = 1'b0; found = 1'b0; g = 0;
        if (!blocked && m_out < DEPTH) begin
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (!found && req_valid[c]) begin found = 1'b1; g = c; end
            end
            e_iss = found;
        end
        e_a = '0; e_b = '0;
        if (e_iss) begin
            e_rdy[g] = 1'b1;
            e_a = req_a[g*W +: W];
            e_b = req_b[g*W +: W];
        end
        chk("req_ready", req_ready, e_rdy);
        chk("add_valid", add_valid, e_iss);
        chk("add_a", add_a, e_a);
        chk("add_b", add_b, e_b);

        e_rv = !blocked && sbq.size() > 0 && sbq[0].rdy <= mcyc;
        chk("res_valid", res_valid, e_rv);
        if (e_rv) begin
            chk("res_sum", res_sum, sbq[0].sum);
            chk("res_id", res_id, sbq[0].id);
        end else if (blocked) begin
            chk("res_sum_rst", res_sum, 0);
            chk("res_id_rst", res_id, 0);
        end
        popped = e_rv && res_ready;

        if (add_valid) begin
            n_iss++;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) glog.push_back(i);
        end
        if (res_valid) n_rv++;
        if (res_valid && res_ready) n_pop++;

        if (rst) begin
            sbq.delete(); sched.delete();
            m_last = NREQ - 1; m_out = 0; m_blank = 1'b1;
        end else begin
            m_blank = 1'b0;
            if (e_iss) begin
                sbq.push_back('{sum: fadd(e_a, e_b), id: g, rdy: mcyc + LAT + 1});
                sched[mcyc + LAT] = fadd(add_a, add_b);
                m_last = g;
                m_out++;
            end
            if (popped) begin
                void'(sbq.pop_front());
                m_out--;
            end
        end
        mcyc++;
    end

    task automatic cyc(input logic [NREQ-1:0] v, input logic rr, input logic r);
        @(posedge clk);
        #1;
        rst = r; req_valid = v; res_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = $urandom();
            req_b[i*W +: W] = $urandom();
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    int n0, r0, p0;
    logic [NREQ-1:0] rv;

    initial begin
        cyc('0, 1'b1, 1'b1);
        cyc('0, 1'b1, 1'b1);
        repeat (3) cyc('0, 1'b1, 1'b0);

        p0 = n_pop;
        cyc(4'b0100, 1'b1, 1'b0);
        req_a[2*W +: W] = 32'h3F800000;
        req_b[2*W +: W] = 32'h40000000;
        repeat (6) cyc('0, 1'b1, 1'b0);
        settle();
        chk("single_pops", n_pop - p0, 1);

        glog.delete();
        repeat (16) cyc(4'hF, 1'b1, 1'b0);
        settle();
        chk("rr_some_grants", glog.size() >= 8, 1);
        for (int i = 0; i < glog.size(); i++) chk("rr_order", glog[i], (i + 3) % 4);
        repeat (10) cyc('0, 1'b1, 1'b0);

        n0 = n_iss;
        repeat (10) cyc(4'hF, 1'b0, 1'b0);
        settle();
        chk("bp_issues", n_iss - n0, DEPTH);
        for (int p = 0; p < 3; p++) begin
            n0 = n_iss;
            cyc(4'hF, 1'b1, 1'b0);
            repeat (3) cyc(4'hF, 1'b0, 1'b0);
            settle();
            chk("bp_pulse_issue", n_iss - n0, 1);
        end
        repeat (12) cyc('0, 1'b1, 1'b0);

        repeat (3) cyc(4'hF, 1'b1, 1'b0);
        cyc('0, 1'b1, 1'b1);
        r0 = n_rv;
        repeat (9) cyc('0, 1'b1, 1'b0);
        settle();
        chk("rst_no_res", n_rv - r0, 0);
        glog.delete();
        cyc(4'hF, 1'b1, 1'b0);
        settle();
        chk("rst_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);

        repeat (400) begin
            rv = NREQ'($urandom());
            cyc(rv, ($urandom_range(0, 3) != 0), 1'b0);
        end
        repeat (30) cyc('0, 1'b1, 1'b0);
        settle();
        chk("drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
